// File: rtl/spram_arbiter.sv
// Round-robin two-port arbiter in front of a single-port registered-read memory,
// with a zero-fill clear sequencer and in-order read response routing.
module spram_arbiter #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned A_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req_valid,
  output logic               a_req_ready,
  input  logic               a_req_wr,
  input  logic [A_WIDTH-1:0] a_req_addr,
  input  logic [D_WIDTH-1:0] a_req_wdata,
  output logic               a_rsp_valid,
  output logic [D_WIDTH-1:0] a_rsp_rdata,
  input  logic               b_req_valid,
  output logic               b_req_ready,
  input  logic               b_req_wr,
  input  logic [A_WIDTH-1:0] b_req_addr,
  input  logic [D_WIDTH-1:0] b_req_wdata,
  output logic               b_rsp_valid,
  output logic [D_WIDTH-1:0] b_rsp_rdata,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               rsp_err,
  output logic               mem_wr_en,
  output logic [A_WIDTH-1:0] mem_address,
  output logic [D_WIDTH-1:0] mem_data_in,
  input  logic [D_WIDTH-1:0] mem_data_out,
  input  logic               mem_valid_out
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(MEM_DEPTH - 1);

  typedef struct packed {
    logic valid;
    logic is_read;
    logic port_b;
  } tag_t;

  logic [0:0]         state, state_d;
  logic [A_WIDTH-1:0] count, count_d;
  logic               prio_b, prio_b_d;
  tag_t               s1, s1_d, s2, s2_d;
  logic               mem_wr_en_d;
  logic [A_WIDTH-1:0] mem_address_d;
  logic [D_WIDTH-1:0] mem_data_in_d;
  logic               clear_busy_d, clear_done_d;
  logic               a_rsp_valid_d, b_rsp_valid_d;
  logic [D_WIDTH-1:0] a_rsp_rdata_d, b_rsp_rdata_d;
  logic               rsp_err_d;
  logic               grant_a_c, grant_b_c, arb_open_c;

  // B wins only when A is idle or B holds the round-robin priority.
  assign grant_b_c  = b_req_valid && (!a_req_valid || prio_b);
  assign grant_a_c  = a_req_valid && !grant_b_c;
  assign arb_open_c = !rst && (state == ST_ARB) && !clear_start;
  assign a_req_ready = arb_open_c && grant_a_c;
  assign b_req_ready = arb_open_c && grant_b_c;

  // Next-state and next-output computation.
  always_comb begin
    state_d       = state;
    count_d       = count;
    prio_b_d      = prio_b;
    s1_d          = '0;
    s2_d          = s1;
    mem_wr_en_d   = 1'b0;
    mem_address_d = mem_address;
    mem_data_in_d = mem_data_in;
    clear_busy_d  = 1'b0;
    clear_done_d  = 1'b0;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_rdata_d = a_rsp_rdata;
    b_rsp_rdata_d = b_rsp_rdata;
    rsp_err_d     = rsp_err;

    if (state == ST_CLEAR) begin
      mem_wr_en_d   = 1'b1;
      mem_address_d = count;
      mem_data_in_d = '0;
      if (count == LAST_ADDR) begin
        state_d      = ST_ARB;
        count_d      = '0;
        clear_done_d = 1'b1;
      end else begin
        count_d      = count + A_WIDTH'(1);
        clear_busy_d = 1'b1;
      end
    end else begin
      if (clear_start) begin
        state_d      = ST_CLEAR;
        count_d      = '0;
        clear_busy_d = 1'b1;
      end else if (a_req_ready && a_req_valid) begin
        mem_wr_en_d   = a_req_wr;
        mem_address_d = a_req_addr;
        mem_data_in_d = a_req_wr ? a_req_wdata : '0;
        s1_d          = '{valid: 1'b1, is_read: !a_req_wr, port_b: 1'b0};
        prio_b_d      = 1'b1;
      end else if (b_req_ready && b_req_valid) begin
        mem_wr_en_d   = b_req_wr;
        mem_address_d = b_req_addr;
        mem_data_in_d = b_req_wr ? b_req_wdata : '0;
        s1_d          = '{valid: 1'b1, is_read: !b_req_wr, port_b: 1'b1};
        prio_b_d      = 1'b0;
      end
    end

    // Read data returns two edges after acceptance; route it by tag.
    if (s2.valid && s2.is_read) begin
      if (!mem_valid_out) rsp_err_d = 1'b1;
      if (s2.port_b) begin
        b_rsp_valid_d = 1'b1;
        b_rsp_rdata_d = mem_data_out;
      end else begin
        a_rsp_valid_d = 1'b1;
        a_rsp_rdata_d = mem_data_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ARB;
      count       <= '0;
      prio_b      <= 1'b0;
      s1          <= '0;
      s2          <= '0;
      mem_wr_en   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_rdata <= '0;
      b_rsp_rdata <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      prio_b      <= prio_b_d;
      s1          <= s1_d;
      s2          <= s2_d;
      mem_wr_en   <= mem_wr_en_d;
      mem_address <= mem_address_d;
      mem_data_in <= mem_data_in_d;
      clear_busy  <= clear_busy_d;
      clear_done  <= clear_done_d;
      a_rsp_valid <= a_rsp_valid_d;
      b_rsp_valid <= b_rsp_valid_d;
      a_rsp_rdata <= a_rsp_rdata_d;
      b_rsp_rdata <= b_rsp_rdata_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural single-port registered-read memory.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_wr;
  logic [3:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [31:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [3:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_rdata;
  logic        clear_start, clear_busy, clear_done, rsp_err;
  logic        mem_wr_en;
  logic [3:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic        mem_valid_out, mem_vout, kill_valid;
  logic [31:0] mem_array [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spram_arbiter #(.D_WIDTH(32), .A_WIDTH(4), .MEM_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_wr(a_req_wr),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_wr(b_req_wr),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .rsp_err(rsp_err),
    .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
  );

  // Memory model: registered read, valid_out high after a read, reset from ~rst.
  always_ff @(posedge clk or negedge (~rst)) begin
    if (rst) begin
      mem_data_out <= '0;
      mem_vout     <= 1'b0;
    end else if (mem_wr_en) begin
      mem_array[mem_address] <= mem_data_in;
      mem_vout <= 1'b0;
    end else begin
      mem_data_out <= mem_array[mem_address];
      mem_vout     <= 1'b1;
    end
  end
  assign mem_valid_out = mem_vout && !kill_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] addr, input logic [31:0] data);
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = addr; a_req_wdata = data;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [31:0] data);
    b_req_valid = 1'b1; b_req_wr = 1'b1; b_req_addr = addr; b_req_wdata = data;
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic rd_a(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = addr;
    tick();
    a_req_valid = 1'b0;
    tick();
    tick();
    check_eq(tag, {a_rsp_valid, a_rsp_rdata}, {1'b1, exp});
  endtask

  // Runs from the first CLEAR cycle until clear_done, returning busy count and ready violations.
  task automatic wait_clear(output int nbusy, output logic done, output logic rdy_bad,
                            input logic chk_pre);
    nbusy = 0; done = 1'b0; rdy_bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (chk_pre && c == 1)
        check_eq("pre_clear_rd", {a_rsp_valid, a_rsp_rdata}, {1'b1, 32'h105});
      if (clear_busy) begin
        nbusy++;
        if (a_req_ready || b_req_ready) rdy_bad = 1'b1;
      end
      if (clear_done) begin
        done = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nbusy;
    logic done, rdy_bad;
    rst = 1'b1; kill_valid = 1'b0; clear_start = 1'b0;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_ctl", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, clear_busy,
                           clear_done, rsp_err, mem_wr_en, mem_address}, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Write then read-after-write on port A.
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 4'd3; a_req_wdata = 32'hDEADBEEF;
    #1;
    check_eq("wr_ready", a_req_ready, 1'b1);
    tick();
    check_eq("wr_pins", {mem_wr_en, mem_address, mem_data_in}, {1'b1, 4'd3, 32'hDEADBEEF});
    a_req_wr = 1'b0;
    tick();
    a_req_valid = 1'b0;
    check_eq("rd_pins", {mem_wr_en, mem_address, mem_data_in}, {1'b0, 4'd3, 32'h0});
    tick();
    check_eq("raw_early", a_rsp_valid, 1'b0);
    tick();
    check_eq("raw_rsp", {a_rsp_valid, a_rsp_rdata}, {1'b1, 32'hDEADBEEF});
    check_eq("raw_b_quiet", {b_rsp_valid, rsp_err}, 2'b00);
    tick();
    check_eq("raw_pulse_end", a_rsp_valid, 1'b0);

    // Alternating grants with both ports holding valid.
    wr_a(4'd1, 32'h11);
    wr_b(4'd2, 32'h22);
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd1;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 4'd2;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        a_req_valid = 1'b0; b_req_valid = 1'b0;
      end
      #1;
      if (i < 4)
        check_eq("rr_grant", {a_req_ready, b_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      if (i >= 2) begin
        if ((i - 2) % 2 == 0)
          check_eq("rr_rsp_a", {a_rsp_valid, b_rsp_valid, a_rsp_rdata}, {2'b10, 32'h11});
        else
          check_eq("rr_rsp_b", {a_rsp_valid, b_rsp_valid, b_rsp_rdata}, {2'b01, 32'h22});
      end
    end

    // Asynchronous reset in the middle of traffic.
    a_req_valid = 1'b1; a_req_wr = 1'b1; a_req_addr = 4'd5; a_req_wdata = 32'h55;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 4'd2;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_ctl", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, clear_busy,
                               clear_done, rsp_err, mem_wr_en, mem_address}, '0);
    check_eq("async_rst_data", {|a_rsp_rdata, |b_rsp_rdata, |mem_data_in}, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rr_after_rst", {a_req_ready, b_req_ready}, 2'b10);
    tick();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick();

    // Fill, launch a read, then clear; the read returns pre-clear data.
    for (int i = 0; i < 16; i++) wr_a(4'(i), 32'h100 + 32'(i));
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd5;
    tick();
    a_req_valid = 1'b0;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    a_req_valid = 1'b1; a_req_addr = 4'd7;
    b_req_valid = 1'b1; b_req_wr = 1'b0; b_req_addr = 4'd7;
    wait_clear(nbusy, done, rdy_bad, 1'b1);
    check_eq("clear_done_seen", done, 1'b1);
    check_eq("clear_busy_cycles", 64'(nbusy), 64'd16);
    check_eq("ready_in_clear", rdy_bad, 1'b0);
    check_eq("busy_at_done", clear_busy, 1'b0);
    check_eq("grant_resume", a_req_ready | b_req_ready, 1'b1);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick();
    check_eq("done_pulse_end", clear_done, 1'b0);
    for (int i = 0; i < 16; i++) rd_a("clear_readback", 4'(i), 32'h0);

    // clear_start beats a simultaneous request; A is served at clear_done.
    clear_start = 1'b1;
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd9;
    #1;
    check_eq("clr_blocks_ready", a_req_ready, 1'b0);
    tick();
    clear_start = 1'b0;
    wait_clear(nbusy, done, rdy_bad, 1'b0);
    check_eq("clear2_done_seen", done, 1'b1);
    check_eq("clear2_ready", rdy_bad, 1'b0);
    check_eq("grant_at_done", {a_req_ready, b_req_ready}, 2'b10);
    tick();
    a_req_valid = 1'b0;
    tick();
    tick();
    check_eq("rd_after_clear", {a_rsp_valid, a_rsp_rdata}, {1'b1, 32'h0});

    // Reset one cycle after a read accept drops the response.
    wr_a(4'd1, 32'h77);
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd1;
    tick();
    a_req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("no_rsp_after_rst", {a_rsp_valid, b_rsp_valid}, 2'b00);
    end
    check_eq("err_clear_after_rst", rsp_err, 1'b0);

    // Missing valid_out on a read return sets the sticky error.
    a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = 4'd1;
    tick();
    a_req_valid = 1'b0;
    tick();
    kill_valid = 1'b1;
    tick();
    kill_valid = 1'b0;
    check_eq("rsp_err_set", rsp_err, 1'b1);
    repeat (3) tick();
    check_eq("rsp_err_sticky", rsp_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory (D_WIDTH/A_WIDTH/MEM_DEPTH memory with registered read, valid_out).
- Accepts read/write commands from ports A and B through valid/ready handshakes and drives the memory command pins from registers.
- Returns read data to the requester that issued the read.
- Owns a clear sequencer that zero-fills the whole memory on request.

Parameters:
D_WIDTH, 32, data width; must match the memory.
A_WIDTH, 4, address width; must match the memory.
MEM_DEPTH, 16, number of words cleared by the clear sequence; must be at most 2**A_WIDTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
a_req_valid  in  1  port A command valid.
a_req_ready  out  1  port A command accepted on this edge when high together with valid.
a_req_wr  in  1  1 = write, 0 = read.
a_req_addr  in  A_WIDTH  port A address.
a_req_wdata  in  D_WIDTH  port A write data.
a_rsp_valid  out  1  one-cycle pulse carrying port A read data.
a_rsp_rdata  out  D_WIDTH  port A read data.
b_req_valid, b_req_ready, b_req_wr, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata  same as port A, for port B.
clear_start  in  1  pulse; request a zero-fill of the memory.
clear_busy  out  1  high while the clear sequence runs.
clear_done  out  1  one-cycle pulse when the clear sequence finishes.
rsp_err  out  1  sticky flag: an expected read return was missing.
mem_wr_en  out  1  to memory wr_en.
mem_address  out  A_WIDTH  to memory address.
mem_data_in  out  D_WIDTH  to memory data_in.
mem_data_out  in  D_WIDTH  from memory data_out.
mem_valid_out  in  1  from memory valid_out.

Behaviour:
- Reset (rst high, asynchronous):
  - All outputs go to 0, including readies, rsp valids and data, mem_* pins, clear_busy, clear_done and rsp_err.
  - FSM returns to ARB. The round-robin pointer favours A.
  - In-flight tags are dropped: a read interrupted by reset never produces a response.
- Integration: the memory's active-low reset is driven from ~rst.
- FSM has two states, ARB and CLEAR.
- ARB, grant selection (combinational):
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not served last is granted.
  - The pointer updates only on an accepted handshake.
  - x_req_ready is high only for the granted port, only in ARB, and only when clear_start is low.
  - Ready never depends on a port's own valid except through the grant.
- Accept at edge E0:
  - mem_wr_en, mem_address and mem_data_in are loaded from the winning request. mem_data_in is forced to 0 for reads.
  - Stage-1 tag (valid, is_read, id) is loaded.
  - Throughput is one command per cycle; back-to-back accepts are allowed.
- No accept at E0: mem_wr_en=0 and address/data are held. The memory then performs dummy reads; their mem_valid_out is ignored.
- Pipeline:
  - At E1 the memory executes and the stage-1 tag moves to stage 2.
  - At E2, if the stage-2 tag is a read, the owning port's rsp_valid is pulsed for one cycle with rsp_rdata = mem_data_out.
  - Read latency is 2 cycles from the accepting edge. Writes produce no response.
  - Responses leave in issue order. Writes and reads to the same address are ordered by acceptance order (read-after-write returns the new data).
  - rsp_rdata holds its last value when rsp_valid is low.
- rsp_err: set when a stage-2 read tag sees mem_valid_out=0 at E2. It is cleared only by rst.
- Clear sequence:
  - clear_start seen in ARB takes priority over requests: no grant that cycle, and the FSM moves to CLEAR at the next edge.
  - clear_start while in CLEAR is ignored.
  - In CLEAR, one write per cycle: mem_wr_en=1, mem_address=count, mem_data_in=0, with count running 0..MEM_DEPTH-1.
  - clear_busy is high for exactly MEM_DEPTH cycles.
  - After the last write, clear_done pulses for one cycle and the FSM returns to ARB. Grants resume in the same cycle clear_done is high.
  - Reads accepted before clear_start still complete and return pre-clear data.
- Reset during CLEAR aborts the sequence; clear_done does not pulse.

Test Plan:
1. Assert rst mid-traffic -> all outputs 0 immediately (asynchronously); FSM in ARB; first grant after release goes to A when both ports request.
2. A writes addr 3 = 0xDEADBEEF, then the next cycle A reads addr 3 -> a_rsp_valid pulses 2 cycles after the read accept with 0xDEADBEEF; b_rsp_valid stays 0; rsp_err stays 0.
3. Preload addr1=0x11 and addr2=0x22. A reads addr1 and B reads addr2, both holding valid continuously for 4 accepts -> grants go A,B,A,B; responses alternate 0x11 to A and 0x22 to B, one per cycle.
4. Fill all 16 words, then pulse clear_start -> clear_busy high for 16 cycles with all readies 0; clear_done pulses once; subsequent reads of addrs 0..15 return 0.
5. clear_start in the same cycle as a_req_valid -> a_req_ready low that cycle and throughout CLEAR; A is accepted in the cycle clear_done is high.
6. Assert rst for one cycle one cycle after a read accept -> no rsp_valid pulse afterwards; rsp_err stays 0. Also force mem_valid_out=0 at the response edge -> rsp_err sets and stays set.
